// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory responder: FSM state encoding,
// latency counter width and the byte-lane merge used for partial stores.
// -----------------------------------------------------------------------------
package dm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   // Wide enough for LATENCY-1 with LATENCY up to 15.
   localparam int CNT_W = 4;

   // Lane i of the result comes from new_word when be[i] is set, otherwise
   // from old_word.
   function automatic logic [31:0] merge(input logic [31:0] old_word,
                                         input logic [31:0] new_word,
                                         input logic [3:0]  be);
      logic [31:0] result;
      for (int i = 0; i < 4; i++) begin
         result[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
      end
      return result;
   endfunction

endpackage : dm_pkg

// File: rtl/dm_array.sv
// -----------------------------------------------------------------------------
// dm_array
// Word-organised storage with per-byte write enables, a combinational read of
// the addressed word and a full clear while reset is high.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high; clears every word
//   wr_en     in   commit a write this cycle
//   wr_be     in   byte enables for the write
//   idx       in   word index for both read and write
//   wdata     in   lane-aligned write data
//   rdata     out  current contents of word idx
// -----------------------------------------------------------------------------
module dm_array #(
   parameter int DEPTH_WORDS = 3072,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [3:0]       wr_be,
   input  logic [IDX_W-1:0] idx,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   assign rdata = mem[idx];

   // NOTE: the array is cleared on reset because the responder promises that
   // every word reads as zero after reset; without that clause this block
   // would map onto a plain RAM macro.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
               mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

endmodule : dm_array

// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder
// Far end of the MEM-stage load/store interface. Accepts one request at a
// time, performs a byte-enabled word read or write LATENCY cycles after
// acceptance, and holds the response until the requester takes it. Every
// committed write prints the store trace line.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   req_valid    in   request present
//   req_ready    out  responder idle and able to accept
//   req_we       in   1 = write, 0 = read
//   req_addr     in   byte address (bits [1:0] ignored for indexing)
//   req_wdata    in   lane-aligned write data
//   req_be       in   byte enables
//   req_pc       in   PC of the issuing instruction (trace only)
//   resp_valid   out  response present
//   resp_ready   in   requester consumes the response
//   resp_rdata   out  read data, or merged post-write word for writes
//   resp_err     out  address was out of range
// -----------------------------------------------------------------------------
module dm_responder
   import dm_pkg::*;
#(
   parameter int          DEPTH_WORDS = 3072,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_pc,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("dm_responder: LATENCY must be in 1..15");
   end

   state_e             state_q,      state_d;
   logic [CNT_W-1:0]   cnt_q,        cnt_d;
   logic               we_q,         we_d;
   logic [31:0]        addr_q,       addr_d;
   logic [31:0]        wdata_q,      wdata_d;
   logic [3:0]         be_q,         be_d;
   logic [31:0]        pc_q,         pc_d;
   logic               req_ready_q,  req_ready_d;
   logic               resp_valid_q, resp_valid_d;
   logic [31:0]        rdata_q,      rdata_d;
   logic               err_q,        err_d;

   logic [31:0]        offset;
   logic               in_range;
   logic [IDX_W-1:0]   idx;
   logic [31:0]        rd_word;
   logic [31:0]        merged;
   logic               access;
   logic               wr_en;

   // Range check on the latched address; an out-of-range request never
   // reaches the array, so the index is parked at 0.
   assign offset   = addr_q - BASE_ADDR;
   assign in_range = (addr_q >= BASE_ADDR) && ((offset >> 2) < 32'(DEPTH_WORDS));
   assign idx      = in_range ? offset[IDX_W+1:2] : '0;
   assign merged   = merge(rd_word, wdata_q, be_q);

   // The access edge is the one leaving BUSY.
   assign access   = (state_q == BUSY) && (cnt_q == '0);
   assign wr_en    = access && we_q && in_range && (be_q != 4'b0000);

   dm_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk   (clk),
      .reset (reset),
      .wr_en (wr_en),
      .wr_be (be_q),
      .idx   (idx),
      .wdata (wdata_q),
      .rdata (rd_word)
   );

   // NOTE: every signal is given its hold value first so no path through the
   // case statement leaves a _d undriven, which would infer a latch.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      pc_d         = pc_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = resp_valid_q;
      rdata_d      = rdata_q;
      err_d        = err_q;

      unique case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               we_d        = req_we;
               addr_d      = req_addr;
               wdata_d     = req_wdata;
               be_d        = req_be;
               pc_d        = req_pc;
               cnt_d       = CNT_W'(LATENCY - 1);
               req_ready_d = 1'b0;
               state_d     = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               resp_valid_d = 1'b1;
               state_d      = RESP;
               if (!in_range) begin
                  rdata_d = '0;
                  err_d   = 1'b1;
               end else begin
                  rdata_d = we_q ? merged : rd_word;
                  err_d   = 1'b0;
               end
            end
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               req_ready_d  = 1'b1;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
      endcase
   end

   // NOTE: state is updated with non-blocking assignments only, so every flop
   // samples the values computed before this edge regardless of block order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         pc_q         <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         pc_q         <= pc_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
         // Store trace: one line per committed write, suppressed under reset.
         if (wr_en) begin
            $display("@%h: *%h <= %h", pc_q, {addr_q[31:2], 2'b00}, merged);
         end
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule : dm_responder

// File: tb/tb_dm_responder.sv
// -----------------------------------------------------------------------------
// tb_dm_responder
// Scoreboard bench: the driver computes each expected response from a simple
// word-array model at acceptance time and queues it together with the cycle
// its response must appear; an independent monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_dm_responder;

   localparam int          DEPTH = 3072;
   localparam int          LAT   = 2;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata, req_pc;
   logic [3:0]  req_be;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;

   dm_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT),
      .BASE_ADDR   (BASE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_be     (req_be),
      .req_pc     (req_pc),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl [DEPTH];

   function automatic void model_clear();
      for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
   endfunction

   // Memory semantics from first principles: byte-granular update of the
   // word the address falls in, or an error for anything outside the window.
   function automatic exp_t model_access(input logic we, input logic [31:0] addr,
                                         input logic [31:0] wdata, input logic [3:0] be);
      exp_t        e;
      longint      word;
      e.due = 0;
      word  = (longint'(addr) - longint'(BASE)) / 4;
      if (longint'(addr) < longint'(BASE) || word >= DEPTH) begin
         e.rdata = '0;
         e.err   = 1'b1;
      end else begin
         if (we) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) mdl[int'(word)][8*b +: 8] = wdata[8*b +: 8];
            end
         end
         e.rdata = mdl[int'(word)];
         e.err   = 1'b0;
      end
      return e;
   endfunction

   // ---------------- response consumer ----------------
   bit rr_en = 1'b1;
   initial begin
      resp_ready = 1'b0;
      forever begin
         @(negedge clk);
         resp_ready = rr_en && ($urandom_range(0, 2) != 0);
      end
   end

   // ---------------- monitor ----------------
   logic prev_v = 1'b0;
   exp_t cur;
   always @(negedge clk) begin
      if (resp_valid && !prev_v) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_resp: got rdata %h err %b, expected no response", resp_rdata, resp_err);
         end else begin
            cur = sb.pop_front();
            check("resp_rdata", resp_rdata, cur.rdata);
            check("resp_err",   32'(resp_err), 32'(cur.err));
            check("latency",    cyc, cur.due);
         end
      end else if (resp_valid && prev_v) begin
         check("hold_rdata", resp_rdata, cur.rdata);
      end
      if (resp_valid) check("req_ready_in_resp", 32'(req_ready), 32'd0);
      prev_v = resp_valid;
   end

   // ---------------- driver ----------------
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] pc, input bit keep = 1'b0);
      exp_t e;
      int   guard = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      req_pc    = pc;
      while (!req_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) begin
         n_checks++;
         $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles, expected 1", guard);
         req_valid = 1'b0;
         return;
      end
      // Accepted on the coming rising edge.
      e     = model_access(we, addr, wdata, be);
      e.due = cyc + 1 + LAT;
      sb.push_back(e);
      @(negedge clk);
      if (!keep) begin
         req_valid = 1'b0;
         req_we    = 1'($urandom);
         req_addr  = $urandom;
         req_wdata = $urandom;
         req_be    = 4'($urandom);
      end
   endtask

   task automatic drain();
      int guard = 0;
      while ((sb.size() != 0 || resp_valid) && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() != 0 || resp_valid) begin
         n_checks++;
         $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
      end
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 5))
         0, 1, 2: return 32'($urandom_range(0, 63));
         3:       return 32'h2FF0 + 32'($urandom_range(0, 23));
         4:       return {$urandom_range(0, 2), 2'b00} + 32'h3000;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
      req_pc    = '0;
      model_clear();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_req_ready",  32'(req_ready),  32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_rdata", resp_rdata,      32'd0);
      check("rst_resp_err",   32'(resp_err),   32'd0);

      // Directed cases.
      do_req(1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'h1000);             // read of cleared word
      do_req(1'b1, 32'h0000_0004, 32'h1234_5678, 4'hF, 32'h3000);     // full write
      do_req(1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'h3004);
      do_req(1'b1, 32'h0000_0004, 32'hAABB_CCDD, 4'b0100, 32'h3008);  // one-lane merge
      do_req(1'b0, 32'h0000_0006, 32'h0, 4'h0, 32'h300C);             // unaligned read, same word
      do_req(1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h3010);
      do_req(1'b1, 32'h0000_3000, 32'hFFFF_FFFF, 4'hF, 32'h3014);     // index 3072: error
      do_req(1'b0, 32'h0000_0000, 32'h0, 4'hF, 32'h3018);
      do_req(1'b1, 32'h0000_000C, 32'h5555_5555, 4'b0000, 32'h301C);  // no lanes enabled
      do_req(1'b0, 32'h0000_000C, 32'h0, 4'hF, 32'h3020);
      do_req(1'b1, 32'h0000_2FFC, 32'h0BAD_BEEF, 4'b1001, 32'h3024);  // last word
      do_req(1'b0, 32'h0000_2FFC, 32'h0, 4'hF, 32'h3028);
      do_req(1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 32'h302C);
      drain();

      // Backpressure: response held, request kept asserted, no re-acceptance.
      rr_en = 1'b0;
      do_req(1'b0, 32'h0000_0004, 32'h0, 4'hF, 32'h4000, 1'b1);
      req_addr = 32'h0000_0000;
      repeat (LAT + 5) begin
         @(negedge clk);
         check("hold_req_ready", 32'(req_ready), 32'd0);
      end
      check("hold_resp_valid", 32'(resp_valid), 32'd1);
      req_valid = 1'b0;
      rr_en     = 1'b1;
      drain();

      // Reset while a write is in BUSY.
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h0000_0008;
      req_wdata = 32'hDEAD_BEEF;
      req_be    = 4'hF;
      req_pc    = 32'h5000;
      check("pre_abort_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      check("abort_busy", 32'(req_ready), 32'd0);
      req_valid = 1'b0;
      reset     = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      check("abort_resp_valid", 32'(resp_valid), 32'd0);
      check("abort_req_ready",  32'(req_ready),  32'd1);
      do_req(1'b0, 32'h0000_0008, 32'h0, 4'hF, 32'h5004);
      do_req(1'b0, 32'h0000_0004, 32'h0, 4'hF, 32'h5008);
      drain();

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         do_req(1'($urandom), rand_addr(), $urandom, 4'($urandom), $urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global time limit so the bench always terminates.
   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation ran past limit, expected completion");
      $fatal(1, "timeout");
   end

endmodule : tb_dm_responder

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder on the far end of the pipeline's MEM-stage load/store interface.
- Accepts one request at a time over a valid/ready handshake and performs a byte-enabled word read or write after a fixed latency.
- Returns a response over a valid/ready handshake; the pipeline's hazard control stalls MEM on `req_ready`/`resp_valid`.
- Emits the standard store trace line on every committed write.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words in the array (12 KiB).
- LATENCY, 2, cycles from request acceptance to the response becoming valid; legal range 1..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address; bits [1:0] ignored for indexing.
- req_wdata  input  32  write data, already lane-aligned.
- req_be  input  4  byte enables; bit i selects bits [8i+7:8i].
- req_pc  input  32  PC of the issuing instruction, used only for the trace.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester consumes the response.
- resp_rdata  output  32  read data; for writes, the merged post-write word.
- resp_err  output  1  address was out of range.

Behaviour:
- Reset, one clock with reset=1:
  - state = IDLE; req_ready = 1; resp_valid = 0; resp_rdata = 0; resp_err = 0; latency counter = 0.
  - All array words cleared to 0.
  - Any in-flight request is aborted, its pending write is discarded, and no trace line is printed.
- Word index = (req_addr - BASE_ADDR) >> 2. The request is in range iff req_addr >= BASE_ADDR and index < DEPTH_WORDS.
- State IDLE:
  - req_ready = 1.
  - On a rising edge with req_valid && req_ready: latch we, addr, wdata, be and pc; load counter = LATENCY-1; go to BUSY.
- State BUSY:
  - req_ready = 0.
  - While counter != 0, decrement each cycle.
  - When counter == 0, the next edge performs the access and goes to RESP.
  - Read: resp_rdata = array[index] and resp_err = 0.
  - Write, in range: each lane with be[i]=1 takes wdata lane i and other lanes keep their old value. resp_rdata = merged word. Trace prints `"@%h: *%h <= %h"` with pc, the word-aligned address and the merged word, once per commit.
  - Write with be = 4'b0000: no array change and no trace; response still issued.
  - Out of range: no array change, no trace, resp_rdata = 0, resp_err = 1.
- State RESP:
  - resp_valid = 1; req_ready = 0.
  - resp_rdata and resp_err hold stable until the handshake.
  - On resp_ready = 1 at an edge: resp_valid drops to 0, go to IDLE.
- Timing:
  - If accepted at edge N, resp_valid rises after edge N+LATENCY.
  - The earliest next acceptance is the edge after the response handshake, so peak throughput is one request per LATENCY+2 cycles.
- Ordering: strictly one outstanding request, so a read after a write to the same word always returns the written data.
- req_valid outside IDLE is ignored. The requester must hold req_valid and its fields stable until accepted.
- resp_ready outside RESP is ignored.

Decomposition:
- Package dm_pkg:
  - State enum {IDLE, BUSY, RESP}.
  - Latency counter width (4).
  - Byte-merge function merge(old, new, be).
  - Trace format string.
- Sub-module dm_array: synchronous word array with 4-lane byte write enable, combinational read of the addressed word, and full clear on reset.
- dm_responder holds the FSM, counter, range check, response registers and trace.

Test Plan:
- Reset, then read addr 0x0000_0010 → resp_valid rises exactly LATENCY (2) cycles after acceptance, resp_rdata=0, resp_err=0.
- Write 0x1234_5678 be=4'hF at 0x0000_0004 (pc 0x3000), then read it back → trace `"@00003000: *00000004 <= 12345678"` and read returns 0x1234_5678.
- Write 0xAABB_CCDD be=4'b0100 over word 0x1234_5678 → resp_rdata=0x12BB_5678 and a later read matches.
- Write to 0x0000_3000 (index 3072) → resp_err=1, resp_rdata=0, no trace, and a read of word 0 is unchanged.
- Hold resp_ready=0 for 5 cycles in RESP while req_valid=1 → resp_valid and data stay stable, req_ready=0, no second acceptance.
- Assert reset during BUSY of a write to 0x8 → after reset, resp_valid=0, req_ready=1, no trace, and a read of 0x8 returns 0.
